// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB initiator and its wait-state timer.
//   - apb_state_e : initiator state encoding (IDLE=0, SETUP=1, ACCESS=2)
//   - APB_ADDR_W / APB_DATA_W : default address and data widths
//   - wdt_width() : width of the wait counter for a given timeout
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 4;
    localparam int APB_DATA_W = 8;

    // Enough bits to hold TIMEOUT; a disabled timeout still gets one bit.
    function automatic int wdt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_wdt.sv
// apb_wdt: counts ACCESS cycles in which the slave holds pready low.
// Ports:
//   clk_i      - bus clock
//   rst_i      - asynchronous active-high reset
//   clear_i    - restart the count (asserted when a transfer enters SETUP)
//   count_en_i - one wait state observed this cycle
//   expired_o  - the wait state being counted now is the last one allowed
// TIMEOUT = 0 disables expiry; the counter then just saturates.
module apb_wdt
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int CW = wdt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry compares against TIMEOUT-1: the count still holds the number of
    // earlier wait states, so the current one is the TIMEOUT-th.
    assign expired_o = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_m.sv
// apb_m: APB initiator for single read/write commands.
// Request side : req_valid/req_ready handshake with req_write, req_addr, req_wdata.
// Response side: one-cycle rsp_valid strobe with rsp_rdata and rsp_err (timeout).
// APB side     : psel, penable, pwrite, paddr, pwdata out; prdata, pready in.
// Clock pclk, asynchronous active-high reset preset. All outputs are registered
// except req_ready, which is high exactly while the initiator is idle.
module apb_m
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic wdt_clear;
    logic wdt_en;
    logic wdt_expired;

    apb_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk_i      (pclk),
        .rst_i      (preset),
        .clear_i    (wdt_clear),
        .count_en_i (wdt_en),
        .expired_o  (wdt_expired)
    );

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        wdt_clear   = 1'b0;
        wdt_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (req_valid) begin
                    pwrite_d  = req_write;
                    paddr_d   = req_addr;
                    pwdata_d  = req_write ? req_wdata : '0;
                    psel_d    = 1'b1;
                    wdt_clear = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready is checked first so a completion on the timeout edge wins.
                if (pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    wdt_en = 1'b1;
                    if (wdt_expired) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
